// File: rtl/word_packer.sv
// Narrow-to-wide packer: RATIO beats of IN_W bits form one MSB-first word held
// in a single registered output slot, with partial-word flush and beat count.
module word_packer #(
   parameter int IN_W  = 8,
   parameter int RATIO = 2,
   parameter int CNT_W = $clog2(RATIO + 1),
   localparam int OUT_W = IN_W * RATIO
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   input  logic             flush,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   input  logic             out_ready,
   output logic             out_nonzero
);

   localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [OUT_W-1:0] acc;
   logic [OUT_W-1:0] merged;
   logic [CW-1:0]    cnt;
   logic             last;
   logic             slot_free;
   logic             accept;
   logic             load_full;
   logic             load_flush;
   logic             load;
   logic [CNT_W-1:0] load_count;

   assign last      = (cnt == CW'(RATIO - 1));
   assign slot_free = !out_valid || out_ready;
   // Only a beat or flush that would load the slot has to wait for it.
   assign in_ready  = (!last && !flush) ? 1'b1 : slot_free;
   assign accept    = in_valid && in_ready;

   // Accumulator with the beat arriving this cycle dropped into its slice.
   for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign merged[OUT_W-1-gi*IN_W -: IN_W] =
         (accept && (cnt == CW'(gi))) ? in_data : acc[OUT_W-1-gi*IN_W -: IN_W];
   end

   assign load_full  = accept && last;
   assign load_flush = flush && slot_free && ((cnt != '0) || accept);
   assign load       = load_full || load_flush;
   assign load_count = load_full ? CNT_W'(RATIO) : (CNT_W'(cnt) + CNT_W'(accept));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc         <= '0;
         cnt         <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_count   <= '0;
         out_nonzero <= 1'b0;
      end else if (load) begin
         out_valid   <= 1'b1;
         out_data    <= merged;
         out_count   <= load_count;
         out_nonzero <= |merged;
         acc         <= '0;
         cnt         <= '0;
      end else begin
         if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            acc <= merged;
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
